// File: rtl/ascon_pack.sv
// Shared ASCON types: the 320-bit state, the XOR-injection operation codes and rate constants.
package ascon_pack;

  localparam int RATE_128  = 64;
  localparam int RATE_128A = 128;

  // Element [i] is state word xi.
  typedef logic [4:0][63:0] type_state;

  typedef enum logic [2:0] {
    XM_PASS      = 3'd0,
    XM_DATA      = 3'd1,
    XM_KEY_BEGIN = 3'd2,
    XM_KEY_END   = 3'd3,
    XM_DOMAIN    = 3'd4,
    XM_TAG       = 3'd5
  } xor_mode_t;

endpackage

// File: rtl/ascon_pad.sv
// Turns a valid-byte count into a MSB-first byte mask and the 0x80 padding byte that follows it.
module ascon_pad
  import ascon_pack::*;
#(
  parameter int RATE_W = RATE_128
) (
  input  logic [$clog2(RATE_W/8):0] bytes_i,
  output logic [RATE_W-1:0]         mask_o,
  output logic [RATE_W-1:0]         pad_o,
  output logic                      ovf_o
);

  localparam int NB = RATE_W / 8;
  localparam int BW = $clog2(NB) + 1;

  // Byte b counts from the MSB; a full block has no pad byte since b never reaches NB.
  for (genvar b = 0; b < NB; b++) begin : g_byte
    assign mask_o[RATE_W-1-8*b -: 8] = (bytes_i > BW'(b))  ? 8'hFF : 8'h00;
    assign pad_o[RATE_W-1-8*b -: 8]  = (bytes_i == BW'(b)) ? 8'h80 : 8'h00;
  end

  assign ovf_o = (bytes_i > BW'(NB));

endmodule

// File: rtl/ascon_xor_inject.sv
// Registered XOR-injection stage between the ASCON state register and the permutation.
module ascon_xor_inject
  import ascon_pack::*;
#(
  parameter int RATE_W = RATE_128
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  xor_mode_t                 mode_i,
  input  logic                      decrypt_i,
  input  type_state                 state_i,
  input  logic [RATE_W-1:0]         data_i,
  input  logic [$clog2(RATE_W/8):0] bytes_i,
  input  logic [127:0]              key_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output type_state                 state_o,
  output logic [RATE_W-1:0]         text_o,
  output logic [127:0]              tag_o,
  output logic [15:0]               block_cnt_o,
  output logic                      err_o
);

  localparam int         RW    = RATE_W / 64;
  localparam logic [2:0] KE_HI = 3'(RW);
  localparam logic [2:0] KE_LO = 3'(RW + 1);

  logic [RATE_W-1:0] mask, pad, rate_in, rate_out, text_res;
  logic              bytes_ovf, accept, res_ill;
  type_state         data_state, res_state;
  logic [RATE_W-1:0] res_text;
  logic [127:0]      res_tag;

  logic              vld_q, vld_d, err_q, err_d;
  type_state         state_q, state_d;
  logic [RATE_W-1:0] text_q, text_d;
  logic [127:0]      tag_q, tag_d;
  logic [15:0]       cnt_q, cnt_d;

  ascon_pad #(.RATE_W(RATE_W)) u_pad (
    .bytes_i (bytes_i),
    .mask_o  (mask),
    .pad_o   (pad),
    .ovf_o   (bytes_ovf)
  );

  // Rate words x0..x[RW-1] form one MSB-first vector lining up with data_i.
  for (genvar w = 0; w < 5; w++) begin : g_word
    if (w < RW) begin : g_rate
      assign rate_in[RATE_W-1-64*w -: 64] = state_i[w];
      assign data_state[w] = rate_out[RATE_W-1-64*w -: 64];
    end else begin : g_cap
      assign data_state[w] = state_i[w];
    end
  end

  always_comb begin
    if (decrypt_i) begin
      rate_out = ((data_i & mask) | (rate_in & ~mask)) ^ pad;
      text_res = (rate_in ^ data_i) & mask;
    end else begin
      rate_out = rate_in ^ ((data_i & mask) | pad);
      text_res = rate_out & mask;
    end
  end

  always_comb begin
    res_state = state_i;
    res_text  = '0;
    res_tag   = '0;
    res_ill   = 1'b0;
    case (mode_i)
      XM_PASS: begin
      end
      XM_DATA: begin
        if (bytes_ovf) begin
          res_ill = 1'b1;
        end else begin
          res_state = data_state;
          res_text  = text_res;
        end
      end
      XM_KEY_BEGIN: begin
        res_state[3] = state_i[3] ^ key_i[127:64];
        res_state[4] = state_i[4] ^ key_i[63:0];
      end
      XM_KEY_END: begin
        res_state[KE_HI] = state_i[KE_HI] ^ key_i[127:64];
        res_state[KE_LO] = state_i[KE_LO] ^ key_i[63:0];
      end
      XM_DOMAIN: begin
        res_state[4][0] = ~state_i[4][0];
      end
      XM_TAG: begin
        res_tag = {state_i[3] ^ key_i[127:64], state_i[4] ^ key_i[63:0]};
      end
      default: begin
        res_ill = 1'b1;
      end
    endcase
  end

  assign in_ready_o = !vld_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;

  // Result register: loads on accept, otherwise holds until drained.
  always_comb begin
    vld_d   = vld_q;
    state_d = state_q;
    text_d  = text_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (accept) begin
      vld_d   = 1'b1;
      state_d = res_state;
      text_d  = res_text;
      tag_d   = res_tag;
      err_d   = err_q | res_ill;
      if (mode_i == XM_DATA && !res_ill) begin
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      end else if (mode_i == XM_KEY_BEGIN) begin
        cnt_d = '0;
      end
    end else if (out_ready_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      vld_q   <= 1'b0;
      state_q <= '0;
      text_q  <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      state_q <= state_d;
      text_q  <= text_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign out_valid_o = vld_q;
  assign state_o     = state_q;
  assign text_o      = text_q;
  assign tag_o       = tag_q;
  assign block_cnt_o = cnt_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_ascon_xor_inject.sv
// Bench for ascon_xor_inject: one 64-bit-rate and one 128-bit-rate instance against a byte-level model.
module tb_ascon_xor_inject;
  import ascon_pack::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xor_mode_t    mode = XM_PASS;
  logic         dec = 1'b0;
  type_state    st_i = '0;
  logic [127:0] key = '0;
  logic         out_ready = 1'b0;

  logic         v64 = 1'b0, v128 = 1'b0;
  logic [63:0]  d64 = '0;
  logic [127:0] d128 = '0;
  logic [3:0]   b64 = '0;
  logic [4:0]   b128 = '0;

  logic         rdy64, rdy128, ov64, ov128, err64, err128;
  type_state    so64, so128;
  logic [63:0]  txt64;
  logic [127:0] txt128, tag64, tag128;
  logic [15:0]  cnt64, cnt128;

  ascon_xor_inject #(.RATE_W(64)) u64 (
    .clock_i(clk), .reset_i(rst), .in_valid_i(v64), .in_ready_o(rdy64),
    .mode_i(mode), .decrypt_i(dec), .state_i(st_i), .data_i(d64), .bytes_i(b64),
    .key_i(key), .out_valid_o(ov64), .out_ready_i(out_ready), .state_o(so64),
    .text_o(txt64), .tag_o(tag64), .block_cnt_o(cnt64), .err_o(err64)
  );

  ascon_xor_inject #(.RATE_W(128)) u128 (
    .clock_i(clk), .reset_i(rst), .in_valid_i(v128), .in_ready_o(rdy128),
    .mode_i(mode), .decrypt_i(dec), .state_i(st_i), .data_i(d128), .bytes_i(b128),
    .key_i(key), .out_valid_o(ov128), .out_ready_i(out_ready), .state_o(so128),
    .text_o(txt128), .tag_o(tag128), .block_cnt_o(cnt128), .err_o(err128)
  );

  int errors = 0;
  int checks = 0;
  int m_cnt64 = 0, m_cnt128 = 0;
  bit m_err64 = 1'b0, m_err128 = 1'b0;

  task automatic chk(input string nm, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  function automatic type_state rand_st();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference: treats the rate as a byte string, MSB first; data/text right-aligned.
  task automatic model(input int rw, input int m, input bit dc, input type_state s,
                       input logic [127:0] data, input int n, input logic [127:0] k,
                       output type_state so, output logic [127:0] txt,
                       output logic [127:0] tg, output logic [15:0] ce, output bit ee);
    bit ill;
    logic [127:0] r, dl, t;
    int cnt;
    ill = (m > 5) || (m == 1 && n > 8 * rw);
    so = s; txt = '0; tg = '0;
    cnt = (rw == 1) ? m_cnt64 : m_cnt128;
    if (!ill) begin
      case (m)
        1: begin
          r  = (rw == 1) ? {s[0], 64'b0} : {s[0], s[1]};
          dl = (rw == 1) ? (data << 64) : data;
          t  = '0;
          for (int b = 0; b < 8 * rw; b++) begin
            int sh;
            logic [7:0] sb, db, nsb, tb;
            sh = 120 - 8 * b;
            sb = 8'(r >> sh);
            db = 8'(dl >> sh);
            tb = 8'h00;
            nsb = sb;
            if (b < n) begin
              if (dc) begin tb = sb ^ db; nsb = db; end
              else begin nsb = sb ^ db; tb = nsb; end
            end else if (b == n) begin
              nsb = sb ^ 8'h80;
            end
            r = (r & ~(128'hFF << sh)) | (128'(nsb) << sh);
            t = t | (128'(tb) << sh);
          end
          so[0] = r[127:64];
          if (rw == 2) so[1] = r[63:0];
          txt = (rw == 1) ? (t >> 64) : t;
          if (cnt < 65535) cnt++;
        end
        2: begin so[3] = s[3] ^ k[127:64]; so[4] = s[4] ^ k[63:0]; cnt = 0; end
        3: begin
          if (rw == 1) begin so[1] = s[1] ^ k[127:64]; so[2] = s[2] ^ k[63:0]; end
          else begin so[2] = s[2] ^ k[127:64]; so[3] = s[3] ^ k[63:0]; end
        end
        4: so[4][0] = ~s[4][0];
        5: tg = {s[3] ^ k[127:64], s[4] ^ k[63:0]};
        default: ;
      endcase
    end
    if (rw == 1) begin
      m_cnt64 = cnt; m_err64 = m_err64 | ill; ee = m_err64;
    end else begin
      m_cnt128 = cnt; m_err128 = m_err128 | ill; ee = m_err128;
    end
    ce = 16'(cnt);
  endtask

  task automatic chk_out(input int rw, input string nm, input type_state so,
                         input logic [127:0] txt, input logic [127:0] tg,
                         input logic [15:0] ce, input bit ee);
    if (rw == 1) begin
      chk({nm, "/valid"}, ov64, 1'b1);
      chk({nm, "/state"}, so64, so);
      chk({nm, "/text"}, txt64, txt[63:0]);
      chk({nm, "/tag"}, tag64, tg);
      chk({nm, "/cnt"}, cnt64, ce);
      chk({nm, "/err"}, err64, ee);
    end else begin
      chk({nm, "/valid"}, ov128, 1'b1);
      chk({nm, "/state"}, so128, so);
      chk({nm, "/text"}, txt128, txt);
      chk({nm, "/tag"}, tag128, tg);
      chk({nm, "/cnt"}, cnt128, ce);
      chk({nm, "/err"}, err128, ee);
    end
  endtask

  task automatic drive(input int rw, input int m, input bit dc, input type_state s,
                       input logic [127:0] data, input int n, input logic [127:0] k);
    mode = xor_mode_t'(m[2:0]);
    dec = dc; st_i = s; key = k;
    if (rw == 1) begin v64 = 1'b1; d64 = data[63:0]; b64 = 4'(n); end
    else begin v128 = 1'b1; d128 = data; b128 = 5'(n); end
  endtask

  task automatic do_req(input int rw, input int m, input bit dc, input type_state s,
                        input logic [127:0] data, input int n, input logic [127:0] k,
                        input string nm);
    type_state so;
    logic [127:0] txt, tg;
    logic [15:0] ce;
    bit ee;
    out_ready = 1'b1;
    drive(rw, m, dc, s, data, n, k);
    model(rw, m, dc, s, data, n, k, so, txt, tg, ce, ee);
    @(posedge clk); #1;
    v64 = 1'b0; v128 = 1'b0;
    chk_out(rw, nm, so, txt, tg, ce, ee);
  endtask

  type_state    s, sa, sb, sc, ea, eb, ec;
  logic [127:0] da, db, dcv, ta, tb, tc, ga, gb, gc, k;
  logic [15:0]  ca, cb, cc;
  bit           ra, rb, rc;

  initial begin
    // Reset state, sampled while reset is held and downstream is stalled.
    repeat (2) @(posedge clk);
    #1;
    chk("rst/valid64", ov64, 1'b0);
    chk("rst/state64", so64, '0);
    chk("rst/cnt64", cnt64, '0);
    chk("rst/err64", err64, 1'b0);
    chk("rst/ready64", rdy64, 1'b1);
    chk("rst/ready128", rdy128, 1'b1);
    chk("rst/tag128", tag128, '0);
    @(negedge clk);
    rst = 1'b0;

    s = '0; s[0] = 64'h0123456789ABCDEF;
    do_req(1, 1, 1'b0, s, 128'hFFFFFFFFFFFFFFFF, 8, '0, "enc_full");
    chk("enc_full/x0", so64[0], 64'hFEDCBA9876543210);
    chk("enc_full/txt", txt64, 64'hFEDCBA9876543210);
    chk("enc_full/cnt1", cnt64, 16'd1);

    s = '0;
    do_req(1, 1, 1'b0, s, 128'hAABBCC0000000000, 3, '0, "enc_part");
    chk("enc_part/x0", so64[0], 64'hAABBCC8000000000);
    chk("enc_part/txt", txt64, 64'hAABBCC0000000000);

    s = '0; s[0] = 64'h1111111111111111; s[1] = 64'h2222222222222222;
    do_req(2, 1, 1'b1, s, {8'h33, 120'h0}, 1, '0, "dec_part");
    chk("dec_part/x0", so128[0], 64'h3391111111111111);
    chk("dec_part/x1", so128[1], 64'h2222222222222222);
    chk("dec_part/txt", txt128, {8'h22, 120'h0});

    k = {64'h1, 64'h2};
    do_req(2, 2, 1'b0, '0, '0, 0, k, "key_begin");
    chk("key_begin/x3", so128[3], 64'h1);
    chk("key_begin/x4", so128[4], 64'h2);
    chk("key_begin/cnt", cnt128, 16'd0);
    do_req(2, 3, 1'b0, so128, '0, 0, k, "key_end");
    chk("key_end/x2", so128[2], 64'h1);

    do_req(1, 4, 1'b1, rand_st(), rand128(), 5, rand128(), "domain64");
    do_req(1, 5, 1'b0, rand_st(), rand128(), 2, rand128(), "tag64");
    do_req(2, 5, 1'b1, rand_st(), rand128(), 3, rand128(), "tag128");
    do_req(1, 3, 1'b0, rand_st(), rand128(), 0, rand128(), "key_end64");

    // Backpressure: three back-to-back data requests, downstream stalls 2 cycles.
    sa = rand_st(); sb = rand_st(); sc = rand_st();
    da = rand128(); db = rand128(); dcv = rand128();
    out_ready = 1'b1;
    drive(1, 1, 1'b0, sa, da, 8, '0);
    model(1, 1, 1'b0, sa, da, 8, '0, ea, ta, ga, ca, ra);
    @(posedge clk); #1;
    chk_out(1, "bp_a", ea, ta, ga, ca, ra);
    drive(1, 1, 1'b1, sb, db, 4, '0);
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("bp/ready_low", rdy64, 1'b0);
      @(posedge clk); #1;
      chk_out(1, "bp_hold", ea, ta, ga, ca, ra);
    end
    out_ready = 1'b1;
    #1;
    chk("bp/ready_high", rdy64, 1'b1);
    model(1, 1, 1'b1, sb, db, 4, '0, eb, tb, gb, cb, rb);
    @(posedge clk); #1;
    chk_out(1, "bp_b", eb, tb, gb, cb, rb);
    drive(1, 1, 1'b0, sc, dcv, 7, '0);
    model(1, 1, 1'b0, sc, dcv, 7, '0, ec, tc, gc, cc, rc);
    @(posedge clk); #1;
    v64 = 1'b0;
    chk_out(1, "bp_c", ec, tc, gc, cc, rc);
    @(posedge clk); #1;
    chk("bp/drained", ov64, 1'b0);
    chk("bp/cnt_held", cnt64, cc);

    // Illegal requests: overflowing byte count, then an undefined mode.
    s = rand_st();
    do_req(1, 1, 1'b0, s, rand128(), 9, '0, "err_bytes");
    chk("err_bytes/err", err64, 1'b1);
    chk("err_bytes/state", so64, s);
    chk("err_bytes/text", txt64, 64'h0);
    s = rand_st();
    do_req(2, 6, 1'b0, s, rand128(), 2, rand128(), "err_mode");
    chk("err_mode/err", err128, 1'b1);

    for (int i = 0; i < 160; i++) begin
      int rw, m, n;
      rw = (i % 2) + 1;
      m = $urandom_range(0, 7);
      if ($urandom_range(0, 2) == 0) m = 1;
      n = $urandom_range(0, 8 * rw + 2);
      do_req(rw, m, 1'($urandom_range(0, 1)), rand_st(), rand128(), n, rand128(), "rand");
    end

    // Asynchronous reset while a new request is pending.
    do_req(2, 1, 1'b0, rand_st(), rand128(), 16, '0, "pre_rst");
    drive(1, 1, 1'b0, rand_st(), rand128(), 8, '0);
    rst = 1'b1;
    #1;
    chk("arst/valid64", ov64, 1'b0);
    chk("arst/valid128", ov128, 1'b0);
    chk("arst/state128", so128, '0);
    chk("arst/text128", txt128, '0);
    chk("arst/cnt128", cnt128, '0);
    chk("arst/err64", err64, 1'b0);
    chk("arst/err128", err128, 1'b0);
    chk("arst/tag64", tag64, '0);
    v64 = 1'b0;
    m_cnt64 = 0; m_cnt128 = 0; m_err64 = 1'b0; m_err128 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_req(1, 1, 1'b0, rand_st(), rand128(), 6, '0, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
